// File: rtl/touch_pkg.sv
// Shared constants, state types and helpers for the touch coordinate sampler.
// Contents: ADS7843 command bytes, SPI frame geometry, top-level and transfer FSM
// state types, and the per-axis jitter distance check.
package touch_pkg;

  // start=1, channel, MODE=1 (8-bit), DFR, PD=00
  localparam logic [7:0] TOUCH_CMD_X = 8'hD8;
  localparam logic [7:0] TOUCH_CMD_Y = 8'h98;

  localparam int unsigned FRAME_SCLKS    = 24;
  localparam int unsigned CMD_BITS       = 8;
  localparam int unsigned DATA_FIRST_CLK = 10;
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StConvX,
    StConvY,
    StAccum,
    StUpdate
  } touch_state_e;

  typedef enum logic [2:0] {
    XferIdle,
    XferLead,
    XferRun,
    XferTail,
    XferGap
  } xfer_state_e;

  // True when |smp - ref_smp| > limit, evaluated as a 9-bit signed difference.
  function automatic logic jitter_exceeds(input logic [7:0] smp, input logic [7:0] ref_smp,
                                          input logic [8:0] limit);
    logic signed [8:0] diff;
    logic        [8:0] mag;
    diff = $signed({1'b0, smp}) - $signed({1'b0, ref_smp});
    mag  = diff[8] ? 9'(-diff) : 9'(diff);
    return mag > limit;
  endfunction

endpackage

// File: rtl/touch_spi_xfer.sv
// One 24-SCLK SPI conversion frame to an ADS7843-class controller.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   start           - one-cycle request, accepted only when idle
//   cmd[7:0]        - command byte shifted out MSB first on clocks 1-8
//   miso            - already-synchronized controller DOUT
//   spi_sclk/cs_n/mosi - SPI pins (SCLK idle low, CS active low)
//   done            - one-cycle pulse once the frame and the CS-high gap are over
//   data[7:0]       - result bits from clocks 10-17, valid from done onwards
module touch_spi_xfer
  import touch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic       miso,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  output logic       done,
  output logic [7:0] data
);

  localparam int unsigned DivW   = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [4:0] LastClk = 5'(FRAME_SCLKS);
  localparam logic [4:0] CmdLast = 5'(CMD_BITS);
  localparam logic [4:0] DataLo  = 5'(DATA_FIRST_CLK);
  localparam logic [4:0] DataHi  = 5'(DATA_FIRST_CLK + DATA_BITS - 1);

  xfer_state_e     st_q, st_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0]      clk_idx_q, clk_idx_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            mosi_q, mosi_d;
  logic            done_q, done_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            tick;

  // One tick per SCLK half-period.
  assign tick = (div_q == DivLast);

  always_comb begin
    st_d      = st_q;
    div_d     = tick ? '0 : div_q + DivW'(1);
    clk_idx_d = clk_idx_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    sh_d      = sh_q;
    data_d    = data_q;
    unique case (st_q)
      XferIdle: begin
        div_d = '0;
        if (start) begin
          cs_n_d    = 1'b0;
          mosi_d    = cmd[7];
          sh_d      = {cmd[6:0], 1'b0};
          data_d    = '0;
          clk_idx_d = '0;
          st_d      = XferLead;
        end
      end
      XferLead: begin
        if (tick) begin
          sclk_d    = 1'b1;
          clk_idx_d = 5'd1;
          st_d      = XferRun;
        end
      end
      XferRun: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            // Capture at the end of the high phase: the synchronizer delay means the
            // synced value here is the bit that was on the pin at the rising edge.
            if (clk_idx_q >= DataLo && clk_idx_q <= DataHi) begin
              data_d = {data_q[6:0], miso};
            end
            if (clk_idx_q < CmdLast) begin
              mosi_d = sh_q[7];
              sh_d   = {sh_q[6:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
            end
            if (clk_idx_q == LastClk) st_d = XferTail;
          end else begin
            sclk_d    = 1'b1;
            clk_idx_d = clk_idx_q + 5'd1;
          end
        end
      end
      XferTail: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          clk_idx_d = '0;
          st_d      = XferGap;
        end
      end
      XferGap: begin
        // Two half-periods of CS high before the next frame may start.
        if (tick) begin
          if (clk_idx_q == 5'd1) begin
            done_d = 1'b1;
            st_d   = XferIdle;
          end else begin
            clk_idx_d = clk_idx_q + 5'd1;
          end
        end
      end
      default: st_d = XferIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= XferIdle;
      div_q     <= '0;
      clk_idx_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      sh_q      <= '0;
      data_q    <= '0;
    end else begin
      st_q      <= st_d;
      div_q     <= div_d;
      clk_idx_q <= clk_idx_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
  assign done     = done_q;
  assign data     = data_q;

endmodule

// File: rtl/touch_coord_sampler.sv
// Touch coordinate sampler: polls an ADS7843-class controller while the pen is down,
// averages 2^AVG_LOG2 X/Y pairs and holds the last valid touch coordinates.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   pen_irq_n, spi_miso   - asynchronous inputs, 2-FF synchronized here
//   spi_sclk/cs_n/mosi    - SPI pins to the controller
//   x_hold, y_hold        - averaged coordinates, held after pen lift
//   touch_valid           - one-cycle pulse when x_hold/y_hold update
//   pen_down              - registered pen state, frozen while CS is low
// Build option: define TOUCH_JITTER_REJECT_EN to drop windows whose samples stray more
// than JITTER_MAX from the window's first sample.
module touch_coord_sampler
  import touch_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 25,
  parameter int unsigned SAMPLE_INTERVAL = 50000,
  parameter int unsigned AVG_LOG2        = 2,
  parameter int unsigned JITTER_MAX      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pen_irq_n,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  output logic [7:0] x_hold,
  output logic [7:0] y_hold,
  output logic       touch_valid,
  output logic       pen_down
);

  localparam int unsigned AccW = 8 + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam int unsigned TmrW = $clog2(SAMPLE_INTERVAL);
  localparam logic [CntW-1:0] CntLast = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(SAMPLE_INTERVAL - 1);

  if (CLK_DIV < 2) begin : gen_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end
  if (AVG_LOG2 > 4) begin : gen_bad_avg_log2
    $error("AVG_LOG2 must be in 0..4");
  end
  if (JITTER_MAX > 255) begin : gen_bad_jitter_max
    $error("JITTER_MAX must fit in 8 bits");
  end

  logic pen_s1_q, pen_s2_q, miso_s1_q, miso_s2_q;
  logic pen_down_q, pen_down_d;

  touch_state_e    state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [AccW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      x_smp_q, x_smp_d, y_smp_q, y_smp_d;
  logic [7:0]      x_hold_q, x_hold_d, y_hold_q, y_hold_d;
  logic            valid_q, valid_d;
  logic            start_q, start_d;

  logic       xfer_done;
  logic [7:0] xfer_data;
  logic [7:0] xfer_cmd;
  logic       jit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_s1_q  <= 1'b1;
      pen_s2_q  <= 1'b1;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      pen_s1_q  <= pen_irq_n;
      pen_s2_q  <= pen_s1_q;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // PENIRQ is meaningless during a conversion, so only track it while CS is high.
  assign pen_down_d = spi_cs_n ? ~pen_s2_q : pen_down_q;

  // start_q and state_q change on the same edge, so the command follows state_q.
  assign xfer_cmd = (state_q == StConvY) ? TOUCH_CMD_Y : TOUCH_CMD_X;

  touch_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_q),
    .cmd      (xfer_cmd),
    .miso     (miso_s2_q),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .done     (xfer_done),
    .data     (xfer_data)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = (tmr_q != '0) ? tmr_q - TmrW'(1) : tmr_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    cnt_d    = cnt_q;
    x_smp_d  = x_smp_q;
    y_smp_d  = y_smp_q;
    x_hold_d = x_hold_q;
    y_hold_d = y_hold_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pen_down_q) begin
          acc_x_d = '0;
          acc_y_d = '0;
          cnt_d   = '0;
          tmr_d   = TmrLoad;
          start_d = 1'b1;
          state_d = StConvX;
        end
      end
      StConvX: begin
        if (xfer_done) begin
          x_smp_d = xfer_data;
          start_d = 1'b1;
          state_d = StConvY;
        end
      end
      StConvY: begin
        if (xfer_done) begin
          y_smp_d = xfer_data;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_x_d = acc_x_q + AccW'(x_smp_q);
        acc_y_d = acc_y_q + AccW'(y_smp_q);
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_q == CntLast) ? StUpdate : StWait;
      end
      StWait: begin
        if (tmr_q == '0) begin
          if (pen_down_q) begin
            tmr_d   = TmrLoad;
            start_d = 1'b1;
            state_d = StConvX;
          end else begin
            acc_x_d = '0;
            acc_y_d = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      StUpdate: begin
        if (pen_down_q && jit_ok) begin
          x_hold_d = acc_x_q[AVG_LOG2 +: 8];
          y_hold_d = acc_y_q[AVG_LOG2 +: 8];
          valid_d  = 1'b1;
        end
        acc_x_d = '0;
        acc_y_d = '0;
        cnt_d   = '0;
        state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_down_q <= 1'b0;
      state_q    <= StIdle;
      tmr_q      <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      cnt_q      <= '0;
      x_smp_q    <= '0;
      y_smp_q    <= '0;
      x_hold_q   <= '0;
      y_hold_q   <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      pen_down_q <= pen_down_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      cnt_q      <= cnt_d;
      x_smp_q    <= x_smp_d;
      y_smp_q    <= y_smp_d;
      x_hold_q   <= x_hold_d;
      y_hold_q   <= y_hold_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
    end
  end

`ifdef TOUCH_JITTER_REJECT_EN
  localparam logic [8:0] JitLimit = 9'(JITTER_MAX);

  logic [7:0] first_x_q, first_x_d, first_y_q, first_y_d;
  logic       jit_bad_q, jit_bad_d;

  // The first pair of a window is the reference; any later pair straying too far
  // poisons the window until UPDATE (or a return to IDLE) clears it.
  always_comb begin
    first_x_d = first_x_q;
    first_y_d = first_y_q;
    jit_bad_d = jit_bad_q;
    if (state_q == StIdle || state_q == StUpdate) begin
      jit_bad_d = 1'b0;
    end else if (state_q == StAccum) begin
      if (cnt_q == '0) begin
        first_x_d = x_smp_q;
        first_y_d = y_smp_q;
      end else if (jitter_exceeds(x_smp_q, first_x_q, JitLimit) ||
                   jitter_exceeds(y_smp_q, first_y_q, JitLimit)) begin
        jit_bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_x_q <= '0;
      first_y_q <= '0;
      jit_bad_q <= 1'b0;
    end else begin
      first_x_q <= first_x_d;
      first_y_q <= first_y_d;
      jit_bad_q <= jit_bad_d;
    end
  end

  assign jit_ok = ~jit_bad_q;
`else
  assign jit_ok = 1'b1;
`endif

  assign x_hold      = x_hold_q;
  assign y_hold      = y_hold_q;
  assign touch_valid = valid_q;
  assign pen_down    = pen_down_q;

endmodule

// File: tb/tb_touch_coord_sampler.sv
module tb_touch_coord_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pen_irq_n = 1'b1;
  logic       spi_miso = 1'b0;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic [7:0] x_hold, y_hold;
  logic       touch_valid, pen_down;

  int tests_run = 0;
  int tests_failed = 0;

  touch_coord_sampler #(
    .CLK_DIV         (2),
    .SAMPLE_INTERVAL (400),
    .AVG_LOG2        (2),
    .JITTER_MAX      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pen_irq_n   (pen_irq_n),
    .spi_miso    (spi_miso),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .x_hold      (x_hold),
    .y_hold      (y_hold),
    .touch_valid (touch_valid),
    .pen_down    (pen_down)
  );

  always #5 clk = ~clk;

  // Controller model, observed on the falling clk edge.
  logic [7:0] x_vals [64];
  logic [7:0] y_vals [64];
  int         x_idx = 0, y_idx = 0;
  logic [7:0] cmd_log [$];
  logic [7:0] cmd_sh = 8'h00, resp = 8'h00;
  int         sclk_n = 0, last_rises = 0, frames = 0;
  int         valid_cnt = 0, valid_long = 0;
  logic       cs_prev = 1'b1, sclk_prev = 1'b0, valid_prev = 1'b0;

  always @(negedge clk) begin
    if (cs_prev && !spi_cs_n) begin
      sclk_n = 0;
      cmd_sh = 8'h00;
    end
    if (!spi_cs_n && spi_sclk && !sclk_prev) begin
      sclk_n++;
      if (sclk_n <= 8) cmd_sh = {cmd_sh[6:0], spi_mosi};
      if (sclk_n == 8) begin
        cmd_log.push_back(cmd_sh);
        if (cmd_sh == 8'hD8) begin
          resp  = x_vals[x_idx];
          x_idx = (x_idx + 1) % 64;
        end else begin
          resp  = y_vals[y_idx];
          y_idx = (y_idx + 1) % 64;
        end
      end
    end
    if (!spi_cs_n && !spi_sclk && sclk_prev) begin
      spi_miso = (sclk_n >= 9 && sclk_n <= 16) ? resp[16 - sclk_n] : 1'b0;
    end
    if (!cs_prev && spi_cs_n) begin
      last_rises = sclk_n;
      frames++;
      spi_miso = 1'b0;
    end
    if (touch_valid) begin
      valid_cnt++;
      if (valid_prev) valid_long++;
    end
    cs_prev    = spi_cs_n;
    sclk_prev  = spi_sclk;
    valid_prev = touch_valid;
  end

  task automatic load_window(input logic [7:0] x0, x1, x2, x3, y0, y1, y2, y3);
    x_vals[(x_idx + 0) % 64] = x0;
    x_vals[(x_idx + 1) % 64] = x1;
    x_vals[(x_idx + 2) % 64] = x2;
    x_vals[(x_idx + 3) % 64] = x3;
    y_vals[(y_idx + 0) % 64] = y0;
    y_vals[(y_idx + 1) % 64] = y1;
    y_vals[(y_idx + 2) % 64] = y2;
    y_vals[(y_idx + 3) % 64] = y3;
  endtask

  task automatic wait_valid(input string name, output int cycles);
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cycles++;
      if (touch_valid) break;
    end
    tests_run++;
    if (touch_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: touch_valid timeout, got %b want 1", name, touch_valid);
    end
  endtask

  task automatic lift_and_settle();
    pen_irq_n = 1'b1;
    repeat (800) @(negedge clk);
  endtask

  task automatic test_reset();
    int f0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_spi: cs/sclk/mosi=%b%b%b want 100", spi_cs_n, spi_sclk, spi_mosi);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (x_hold !== 8'h00 || y_hold !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_hold: x=%h y=%h want 00 00", x_hold, y_hold);
    end
    tests_run++;
    if (touch_valid !== 1'b0 || pen_down !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: valid=%b pen_down=%b want 0 0", touch_valid, pen_down);
    end
    f0 = frames;
    repeat (300) @(negedge clk);
    tests_run++;
    if (frames !== f0) begin
      tests_failed++;
      $display("FAIL reset_no_frame: frames=%0d want %0d", frames, f0);
    end
    tests_run++;
    if (spi_cs_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cs_idle: cs_n=%b want 1", spi_cs_n);
    end
  endtask

  task automatic test_basic();
    int cbase, vbase, cyc;
    load_window(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hC3, 8'hC3, 8'hC3, 8'hC3);
    cbase = cmd_log.size();
    vbase = valid_cnt;
    pen_irq_n = 1'b0;
    wait_valid("basic", cyc);
    tests_run++;
    if (cyc < 1200) begin
      tests_failed++;
      $display("FAIL basic_latency: %0d cycles, want >= 1200", cyc);
    end
    tests_run++;
    if (x_hold !== 8'h5A || y_hold !== 8'hC3) begin
      tests_failed++;
      $display("FAIL basic_xy: x=%h y=%h want 5a c3", x_hold, y_hold);
    end
    tests_run++;
    if (cmd_log.size() < cbase + 2) begin
      tests_failed++;
      $display("FAIL basic_cmd: %0d commands seen, want >= 2", cmd_log.size() - cbase);
    end else if (cmd_log[cbase] !== 8'hD8 || cmd_log[cbase + 1] !== 8'h98) begin
      tests_failed++;
      $display("FAIL basic_cmd: %h %h want d8 98", cmd_log[cbase], cmd_log[cbase + 1]);
    end
    tests_run++;
    if (last_rises !== 24) begin
      tests_failed++;
      $display("FAIL basic_rises: %0d want 24", last_rises);
    end
    lift_and_settle();
    tests_run++;
    if (valid_cnt - vbase !== 1) begin
      tests_failed++;
      $display("FAIL basic_valid_count: %0d want 1", valid_cnt - vbase);
    end
    tests_run++;
    if (valid_long !== 0) begin
      tests_failed++;
      $display("FAIL basic_valid_width: %0d long pulses want 0", valid_long);
    end
  endtask

  task automatic test_average();
    int vbase, cyc;
    load_window(8'd100, 8'd101, 8'd102, 8'd104, 8'd10, 8'd20, 8'd30, 8'd41);
    vbase = valid_cnt;
    pen_irq_n = 1'b0;
    wait_valid("average", cyc);
    tests_run++;
    if (x_hold !== 8'd101 || y_hold !== 8'd25) begin
      tests_failed++;
      $display("FAIL average_xy: x=%0d y=%0d want 101 25", x_hold, y_hold);
    end
    lift_and_settle();
    tests_run++;
    if (valid_cnt - vbase !== 1) begin
      tests_failed++;
      $display("FAIL average_valid_count: %0d want 1", valid_cnt - vbase);
    end
  endtask

  task automatic test_pen_lift();
    int vbase, fbase;
    load_window(8'd200, 8'd200, 8'd200, 8'd200, 8'd90, 8'd90, 8'd90, 8'd90);
    vbase = valid_cnt;
    fbase = frames;
    pen_irq_n = 1'b0;
    for (int i = 0; i < 2000 && frames < fbase + 4; i++) @(negedge clk);
    tests_run++;
    if (frames !== fbase + 4) begin
      tests_failed++;
      $display("FAIL lift_two_pairs: frames=%0d want %0d", frames - fbase, 4);
    end
    pen_irq_n = 1'b1;
    repeat (1500) @(negedge clk);
    tests_run++;
    if (valid_cnt !== vbase) begin
      tests_failed++;
      $display("FAIL lift_no_valid: %0d pulses want 0", valid_cnt - vbase);
    end
    tests_run++;
    if (x_hold !== 8'd101 || y_hold !== 8'd25) begin
      tests_failed++;
      $display("FAIL lift_hold: x=%0d y=%0d want 101 25", x_hold, y_hold);
    end
    tests_run++;
    if (frames !== fbase + 4) begin
      tests_failed++;
      $display("FAIL lift_idle: frames=%0d want 4", frames - fbase);
    end
  endtask

  task automatic test_pen_freeze();
    load_window(8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2);
    pen_irq_n = 1'b0;
    for (int i = 0; i < 500 && !(!spi_cs_n && sclk_n >= 4); i++) @(negedge clk);
    tests_run++;
    if (spi_cs_n !== 1'b0 || pen_down !== 1'b1) begin
      tests_failed++;
      $display("FAIL freeze_start: cs_n=%b pen_down=%b want 0 1", spi_cs_n, pen_down);
    end
    pen_irq_n = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (spi_cs_n !== 1'b0 || pen_down !== 1'b1) begin
      tests_failed++;
      $display("FAIL freeze_hold: cs_n=%b pen_down=%b want 0 1", spi_cs_n, pen_down);
    end
    for (int i = 0; i < 300 && spi_cs_n !== 1'b1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    tests_run++;
    if (pen_down !== 1'b0) begin
      tests_failed++;
      $display("FAIL freeze_release: pen_down=%b want 0", pen_down);
    end
    tests_run++;
    if (last_rises !== 24) begin
      tests_failed++;
      $display("FAIL freeze_rises: %0d want 24", last_rises);
    end
    lift_and_settle();
  endtask

  task automatic test_jitter();
    int vbase, fbase, cyc;
    logic [7:0] exp_x, exp_y;
    int exp_pulses;
`ifdef TOUCH_JITTER_REJECT_EN
    exp_x = 8'd101;
    exp_y = 8'd25;
    exp_pulses = 0;
`else
    exp_x = 8'd105;
    exp_y = 8'd50;
    exp_pulses = 1;
`endif
    load_window(8'd100, 8'd100, 8'd120, 8'd100, 8'd50, 8'd50, 8'd50, 8'd50);
    vbase = valid_cnt;
    fbase = frames;
    pen_irq_n = 1'b0;
    for (int i = 0; i < 2500 && frames < fbase + 8; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    lift_and_settle();
    tests_run++;
    if (valid_cnt - vbase !== exp_pulses) begin
      tests_failed++;
      $display("FAIL jitter_big_pulses: %0d want %0d", valid_cnt - vbase, exp_pulses);
    end
    tests_run++;
    if (x_hold !== exp_x || y_hold !== exp_y) begin
      tests_failed++;
      $display("FAIL jitter_big_xy: x=%0d y=%0d want %0d %0d", x_hold, y_hold, exp_x, exp_y);
    end
    load_window(8'd100, 8'd104, 8'd96, 8'd100, 8'd60, 8'd60, 8'd60, 8'd60);
    pen_irq_n = 1'b0;
    wait_valid("jitter_small", cyc);
    tests_run++;
    if (x_hold !== 8'd100 || y_hold !== 8'd60) begin
      tests_failed++;
      $display("FAIL jitter_small_xy: x=%0d y=%0d want 100 60", x_hold, y_hold);
    end
    lift_and_settle();
  endtask

  task automatic test_reset_midframe();
    int fbase;
    load_window(8'd7, 8'd7, 8'd7, 8'd7, 8'd8, 8'd8, 8'd8, 8'd8);
    pen_irq_n = 1'b0;
    for (int i = 0; i < 500 && !(!spi_cs_n && sclk_n >= 3); i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_abort: cs_n=%b sclk=%b want 1 0", spi_cs_n, spi_sclk);
    end
    tests_run++;
    if (x_hold !== 8'h00 || y_hold !== 8'h00 || pen_down !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_clear: x=%h y=%h pen=%b want 00 00 0", x_hold, y_hold, pen_down);
    end
    pen_irq_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    fbase = frames;
    repeat (300) @(negedge clk);
    tests_run++;
    if (frames !== fbase || touch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_quiet: frames=%0d valid=%b want 0 0", frames - fbase, touch_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_pen_lift();
    test_pen_freeze();
    test_jitter();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
